lit_stream_checker: RTL and testbench
=====================================

LIT_STREAM_CHECKER -- requirements
Module: lit_stream_checker

Interface
REQ-001 Parameter NUM_WORDS, default 8, number of words per frame; legal range 1..8.
REQ-002 Parameter SIG_INIT, default 32'h0000_0000, signature seed loaded on frame start.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a frame.
REQ-006 in_valid  input  1  in_data/in_last valid.
REQ-007 in_ready  output  1  checker accepts a word this cycle.
REQ-008 in_data  input  32  literal word under test.
REQ-009 in_last  input  1  marks final word of frame.
REQ-010 done  output  1  frame complete; results stable.
REQ-011 pass  output  1  frame had zero mismatches and no length error.
REQ-012 err_count  output  4  number of mismatching words in frame.
REQ-013 first_bad  output  3  index of first mismatching word; 0 if none.
REQ-014 len_err  output  1  in_last disagreed with NUM_WORDS.
REQ-015 signature  output  32  running rotate-xor signature of accepted words.

Function
REQ-016 Expected table, index 0..7: DEAD_BEEF, DEAD_BEEF, DEAD_BEEF, A50F_C33C, 0000_00FF, 0000_00FF, 0000_00FF, 0000_0001.
REQ-017 States: IDLE, RUN, DONE; encoding 2 bits.
REQ-018 IDLE: in_ready=0; start=1 -> RUN, clears idx, err_count, first_bad, len_err, pass, done; loads signature=SIG_INIT.
REQ-019 RUN: in_ready=1 combinationally from state only; beat = in_valid && in_ready.
REQ-020 Each beat: compare in_data to table[idx] (full 32 bits); mismatch -> err_count+1, saturating at 15.
REQ-021 first_bad captures idx on the first mismatch only.
REQ-022 Each beat: signature <= {signature[30:0], signature[31]} ^ in_data.
REQ-023 Frame ends on the beat where in_last=1 or idx==NUM_WORDS-1, whichever comes first; -> DONE next cycle.
REQ-024 len_err=1 if the end beat has in_last XOR (idx==NUM_WORDS-1).
REQ-025 idx increments per non-final beat; no beat without in_valid advances idx.
REQ-026 DONE: done=1, in_ready=0, pass = (err_count==0) && !len_err; outputs held.
REQ-027 DONE + start=1 -> RUN with same clearing as REQ-018 (back-to-back frames, one bubble cycle).
REQ-028 start in RUN is ignored; start and a beat in the same RUN cycle: beat processed normally.
REQ-029 Result latency: done rises the cycle after the end beat.

Reset
REQ-030 rst=1 at any clock edge, including mid-frame, forces IDLE; done=0, pass=0, err_count=0, first_bad=0, len_err=0, signature=SIG_INIT, in_ready=0.
REQ-031 rst dominates start in the same cycle.

Structure
REQ-032 Shared package lit_pkg holds the state typedef, the 8-entry expected-word table and WORD_W=32.
REQ-033 One sub-module natural: lit_sig_step (combinational rotate-xor step), instantiated once.

Verification
REQ-034 Eight words per table with in_last on word 7 -> done, pass=1, err_count=0, len_err=0, signature=32'h78FB_27D2.
REQ-035 Same frame, word 3 = 32'hA50F_C33D and word 5 = 32'h0000_00FE -> pass=0, err_count=2, first_bad=3.
REQ-036 in_last asserted on word 5 -> done after 6 beats, len_err=1, pass=0; in_last never asserted -> ends at word 7, len_err=1.
REQ-037 in_valid gapped randomly (50%) on good frame -> identical results to REQ-034; idx never advances on gaps.
REQ-038 rst asserted after word 4 of a frame -> next cycle IDLE with all outputs at reset values; new start then good frame -> pass=1.
REQ-039 start held during RUN and start in DONE -> first ignored, second begins new frame with cleared results.

Source files
------------

// File: rtl/lit_pkg.sv
// lit_pkg: shared word width, checker state type and expected literal table
package lit_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [WORD_W-1:0] EXP_TABLE [8] = '{
    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA50F_C33C,
    32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0001
  };
endpackage

// File: rtl/lit_sig_step.sv
// lit_sig_step: one rotate-left-by-one then xor step of the running signature
module lit_sig_step
  import lit_pkg::*;
(
  input  logic [WORD_W-1:0] sig,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] nxt
);
  assign nxt = {sig[WORD_W-2:0], sig[WORD_W-1]} ^ word;
endmodule

// File: rtl/lit_stream_checker.sv
// lit_stream_checker: compares a frame of streamed words against a fixed literal table
module lit_stream_checker
  import lit_pkg::*;
#(
  parameter int                NUM_WORDS = 8,
  parameter logic [WORD_W-1:0] SIG_INIT  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              done,
  output logic              pass,
  output logic [3:0]        err_count,
  output logic [2:0]        first_bad,
  output logic              len_err,
  output logic [WORD_W-1:0] signature
);
  state_t state, next;
  logic [2:0] idx;
  logic [WORD_W-1:0] sig_nxt;
  logic beat, at_last, end_beat, bad, clear;
  lit_sig_step u_step (.sig(signature), .word(in_data), .nxt(sig_nxt));
  assign beat     = in_valid && in_ready;
  assign at_last  = idx == 3'(NUM_WORDS - 1);
  assign end_beat = beat && (in_last || at_last);
  assign bad      = in_data != EXP_TABLE[idx];
  assign clear    = start && state != RUN;
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    next = state;
    if (state == RUN) next = end_beat ? DONE : RUN;
    else if (start) next = RUN;
  end
  always_comb begin
    in_ready = state == RUN;
    done     = state == DONE;
    pass     = state == DONE && err_count == 4'd0 && !len_err;
  end
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx       <= '0;
      err_count <= '0;
      first_bad <= '0;
      len_err   <= 1'b0;
      signature <= SIG_INIT;
    end else if (beat) begin
      signature <= sig_nxt;
      idx       <= end_beat ? idx : idx + 3'd1;
      if (bad) begin
        err_count <= err_count + 4'(err_count != 4'hF);
        if (err_count == 4'd0) first_bad <= idx;
      end
      if (end_beat) len_err <= in_last ^ at_last;
    end
  end
endmodule

// File: tb/tb_lit_stream_checker.sv
// tb_lit_stream_checker: table-driven frame vectors plus reset and start corner sequences
module tb_lit_stream_checker;
  typedef struct packed {
    logic [7:0][31:0] w;
    logic [3:0]       last_at;
    logic             gap;
    logic             pass;
    logic [3:0]       err;
    logic [2:0]       fb;
    logic             len;
    logic [31:0]      sig;
    logic [3:0]       beats;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, done, pass, len_err;
  logic [3:0] err_count;
  logic [2:0] first_bad;
  logic [31:0] signature;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_tab [8] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA50F_C33C,
                              32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0001};
  vec_t vt [8];
  lit_stream_checker dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .done(done), .pass(pass),
    .err_count(err_count), .first_bad(first_bad), .len_err(len_err), .signature(signature)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic feed(input vec_t v, output int beats, output bit ontime);
    int i = 0, cyc = 0;
    bit acc, g;
    beats = 0;
    ontime = 0;
    while (!done && cyc < 100) begin
      g = v.gap && ($urandom_range(0, 1) == 1);
      in_valid = !g;
      in_data = g ? 32'h1234_5678 : v.w[i % 8];
      in_last = !g && (i == int'(v.last_at));
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        beats++;
        i++;
        if (beats == int'(v.beats)) ontime = done;
      end
      cyc++;
    end
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic chk_res(input string t, input vec_t v, input int beats, input bit ontime);
    chk({t, " done"}, 32'(done), 32'd1);
    chk({t, " in_ready"}, 32'(in_ready), 32'd0);
    chk({t, " pass"}, 32'(pass), 32'(v.pass));
    chk({t, " err_count"}, 32'(err_count), 32'(v.err));
    chk({t, " first_bad"}, 32'(first_bad), 32'(v.fb));
    chk({t, " len_err"}, 32'(len_err), 32'(v.len));
    chk({t, " signature"}, signature, v.sig);
    chk({t, " beats"}, 32'(beats), 32'(v.beats));
    chk({t, " latency"}, 32'(ontime), 32'd1);
  endtask
  task automatic run_frame(input string t, input vec_t v);
    int beats;
    bit ontime;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    feed(v, beats, ontime);
    chk_res(t, v, beats, ontime);
  endtask
  task automatic chk_reset(input string t);
    chk({t, " done"}, 32'(done), 32'd0);
    chk({t, " pass"}, 32'(pass), 32'd0);
    chk({t, " err_count"}, 32'(err_count), 32'd0);
    chk({t, " first_bad"}, 32'(first_bad), 32'd0);
    chk({t, " len_err"}, 32'(len_err), 32'd0);
    chk({t, " signature"}, signature, 32'd0);
    chk({t, " in_ready"}, 32'(in_ready), 32'd0);
  endtask
  initial begin
    vec_t good, v;
    int beats;
    bit ontime;
    for (int i = 0; i < 8; i++) good.w[i] = exp_tab[i];
    good.last_at = 4'd7; good.gap = 0; good.pass = 1; good.err = 0; good.fb = 0;
    good.len = 0; good.sig = 32'h78FB_27D2; good.beats = 4'd8;
    vt[0] = good;
    v = good; v.w[3] = 32'hA50F_C33D; v.w[5] = 32'h0000_00FE;
    v.pass = 0; v.err = 4'd2; v.fb = 3'd3; v.sig = 32'h78FB_27C6; vt[1] = v;
    v = good; v.last_at = 4'd5; v.pass = 0; v.len = 1; v.sig = 32'h5E3E_C98B; v.beats = 4'd6; vt[2] = v;
    v = good; v.last_at = 4'd8; v.pass = 0; v.len = 1; vt[3] = v;
    v = good; v.w = '0; v.pass = 0; v.err = 4'd8; v.fb = 3'd0; v.sig = 32'h0; vt[4] = v;
    v = good; v.w[7] = 32'h0; v.pass = 0; v.err = 4'd1; v.fb = 3'd7; v.sig = 32'h78FB_27D3; vt[5] = v;
    v = good; v.last_at = 4'd0; v.pass = 0; v.len = 1; v.sig = 32'hDEAD_BEEF; v.beats = 4'd1; vt[6] = v;
    v = good; v.gap = 1; vt[7] = v;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_reset("reset");
    for (int k = 0; k < 8; k++) run_frame($sformatf("vec%0d", k), vt[k]);
    repeat (2) @(posedge clk);
    #1;
    chk("hold err_count", 32'(err_count), 32'(vt[7].err));
    chk("hold signature", signature, vt[7].sig);
    chk("hold pass", 32'(pass), 32'd1);
    start = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = exp_tab[i];
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    start = 0;
    chk_reset("midrst");
    @(posedge clk); #1;
    chk("midrst idle in_ready", 32'(in_ready), 32'd0);
    run_frame("after_rst", vt[0]);
    start = 1;
    @(posedge clk); #1;
    feed(vt[1], beats, ontime);
    chk_res("held_start", vt[1], beats, ontime);
    @(posedge clk); #1;
    start = 0;
    chk("restart done", 32'(done), 32'd0);
    chk("restart in_ready", 32'(in_ready), 32'd1);
    chk("restart err_count", 32'(err_count), 32'd0);
    chk("restart first_bad", 32'(first_bad), 32'd0);
    chk("restart signature", signature, 32'd0);
    feed(vt[0], beats, ontime);
    chk_res("restart", vt[0], beats, ontime);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
